nvdla_cmac_core_wt_sched: RTL and testbench
===========================================

Name: nvdla_cmac_core_wt_sched

Overview:
- Sequences weight and feature-data traffic into the CMAC core active/shadow datapath.
- Assigns each incoming weight atom to one of ATOMK_HALF shadow kernel slots by driving one-hot in_wt_sel.
- Holds back any data beat carrying stripe-start until the shadow set is full, so each stripe start pops a complete kernel group into the active registers.
- Counts stripes per operation and reports completion.
- Sits between the CSC-side weight/data streams and the core active datapath.

Parameters:
ATOMK_HALF, 8, number of kernel slots (width of in_wt_sel)
ATOMC, 64, atomic channel count (mask width)
STRIPE_W, 16, stripe counter width
KNUM_W, 4, width of cfg_kernel_num (must hold ATOMK_HALF)

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rst  in  1  synchronous reset, active-high
op_start  in  1  one-cycle pulse; samples cfg_kernel_num and op_stripe_num
cfg_kernel_num  in  KNUM_W  kernels per group, legal range 1..ATOMK_HALF
op_stripe_num  in  STRIPE_W  stripes in the operation
wt_in_pvld  in  1  weight beat valid
wt_in_prdy  out  1  weight beat ready
wt_in_mask  in  ATOMC  weight nonzero mask
dat_in_pvld  in  1  data beat valid
dat_in_prdy  out  1  data beat ready
dat_in_mask  in  ATOMC  data nonzero mask
dat_in_stripe_st  in  1  beat begins a stripe
dat_in_stripe_end  in  1  beat ends a stripe
in_wt_pvld  out  1  weight valid to datapath
in_wt_mask  out  ATOMC  weight mask to datapath
in_wt_sel  out  ATOMK_HALF  one-hot shadow slot select
in_dat_pvld  out  1  data valid to datapath
in_dat_mask  out  ATOMC  data mask to datapath
in_dat_stripe_st  out  1  stripe start to datapath
in_dat_stripe_end  out  1  stripe end to datapath
op_busy  out  1  operation in progress
op_done  out  1  one-cycle completion pulse
err_proto  out  1  sticky protocol error

Behaviour:
- Reset: all outputs and state are 0; shadow FSM goes to S_IDLE. A reset mid-operation abandons the op with no op_done.
- Shadow FSM states are S_IDLE, S_FILL and S_FULL.
- S_IDLE:
  - op_start with op_stripe_num > 0 goes to S_FILL, sets op_busy=1, and clears the slot counter wt_k and the stripe counter st_cnt.
  - op_start with op_stripe_num = 0 pulses op_done the next cycle and stays in S_IDLE.
  - op_start while op_busy is ignored.
- S_FILL:
  - wt_in_prdy=1.
  - Each accepted beat registers in_wt_pvld=1, in_wt_mask=wt_in_mask and in_wt_sel=onehot(wt_k), then increments wt_k.
  - Accepting the beat with wt_k = kernel_num-1 goes to S_FULL and clears wt_k.
- S_FULL: wt_in_prdy=0.
- dat_in_prdy:
  - 0 when dat_in_stripe_st=1 and the state is not S_FULL.
  - Otherwise 1 while op_busy.
  - 0 when not op_busy.
- Accepted data beats register the in_dat_* outputs. The stripe flags are qualified by acceptance. Output latency is 1 cycle for both streams; outputs are 0 in cycles with no acceptance.
- Accepted stripe_st:
  - Increments st_cnt and sets stripe_active.
  - If st_cnt+1 < op_stripe_num, goes to S_FILL.
  - Otherwise goes to S_IDLE and no further weights are accepted.
- Accepted stripe_end: clears stripe_active. If it ends the final stripe, op_done pulses the next cycle and op_busy clears.
- Timing guarantees:
  - A stripe_st beat is accepted no earlier than 1 cycle after the last weight beat, so the shadow write completes before the pop.
  - A refill beat is accepted no earlier than 1 cycle after stripe_st, so the pop reads the old shadow before the overwrite.
- A beat with stripe_st and stripe_end both set is a one-beat stripe: apply the start rule, then the end rule.
- err_proto is sticky until reset. It is set by:
  - stripe_st accepted while stripe_active;
  - stripe_end accepted while not stripe_active;
  - cfg_kernel_num = 0 or > ATOMK_HALF at op_start. In this case the op is not started.
- wt_k and st_cnt never wrap within a legal op.

Decomposition:
- Package nvdla_cmac_sched_pkg holds:
  - the shadow-state encoding (S_IDLE, S_FILL, S_FULL);
  - the onehot function;
  - ATOMK_HALF/ATOMC defaults shared with the core.
- Sub-module nvdla_cmac_sched_oreg: a 1-cycle output register stage, instanced twice (weight and data streams).

Test Plan:
- kernel_num=8, stripes=1; 8 weight beats then a stripe_st..end data beat -> in_wt_sel 01,02,..,80 on consecutive cycles; stripe_st output 2 cycles after the last weight at the earliest; op_done 1 cycle after the end beat.
- kernel_num=3; stripe_st presented with weights -> dat_in_prdy=0 until the 3rd weight is accepted, then accepted next cycle; wt_in_prdy=0 that cycle, 1 the following cycle (refill).
- stripes=3 back-to-back -> exactly 3 fill groups; after the 3rd stripe_st, wt_in_prdy stays 0; op_done once; st_cnt=3.
- op_stripe_num=0 -> op_done pulses 1 cycle after op_start; no weight accepted.
- Two stripe_st without an intervening end -> err_proto=1 and held; cfg_kernel_num=9 -> err_proto=1, op_busy stays 0.
- Reset asserted mid-fill (wt_k=4) -> next cycle all outputs 0, S_IDLE, no op_done; a new op_start works normally.

Source files
------------

// File: rtl/nvdla_cmac_sched_pkg.sv
// Shared types, defaults and helpers for the CMAC weight/data scheduler.
// Shadow-state encoding, slot one-hot decode and the core's atom geometry.
package nvdla_cmac_sched_pkg;

  localparam int unsigned ATOMK_HALF_DEF = 8;
  localparam int unsigned ATOMC_DEF      = 64;
  localparam int unsigned STRIPE_W_DEF   = 16;
  localparam int unsigned KNUM_W_DEF     = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } shadow_state_e;

  // Callers size-cast the result down to their slot count.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx[4:0];
  endfunction

endpackage

// File: rtl/nvdla_cmac_core_wt_sched_if.sv
// Weight/data stream bundle between the CSC-side feeder and the CMAC scheduler.
// slave = scheduler view, master = feeder / core-datapath view.
interface nvdla_cmac_core_wt_sched_if
  import nvdla_cmac_sched_pkg::*;
#(
  parameter int unsigned ATOMK_HALF = ATOMK_HALF_DEF,
  parameter int unsigned ATOMC      = ATOMC_DEF
);
  logic                  wt_in_pvld;
  logic                  wt_in_prdy;
  logic [ATOMC-1:0]      wt_in_mask;
  logic                  dat_in_pvld;
  logic                  dat_in_prdy;
  logic [ATOMC-1:0]      dat_in_mask;
  logic                  dat_in_stripe_st;
  logic                  dat_in_stripe_end;
  logic                  in_wt_pvld;
  logic [ATOMC-1:0]      in_wt_mask;
  logic [ATOMK_HALF-1:0] in_wt_sel;
  logic                  in_dat_pvld;
  logic [ATOMC-1:0]      in_dat_mask;
  logic                  in_dat_stripe_st;
  logic                  in_dat_stripe_end;

  modport slave (
    input  wt_in_pvld, wt_in_mask, dat_in_pvld, dat_in_mask,
           dat_in_stripe_st, dat_in_stripe_end,
    output wt_in_prdy, dat_in_prdy,
           in_wt_pvld, in_wt_mask, in_wt_sel,
           in_dat_pvld, in_dat_mask, in_dat_stripe_st, in_dat_stripe_end
  );

  modport master (
    output wt_in_pvld, wt_in_mask, dat_in_pvld, dat_in_mask,
           dat_in_stripe_st, dat_in_stripe_end,
    input  wt_in_prdy, dat_in_prdy,
           in_wt_pvld, in_wt_mask, in_wt_sel,
           in_dat_pvld, in_dat_mask, in_dat_stripe_st, in_dat_stripe_end
  );
endinterface

// File: rtl/nvdla_cmac_sched_oreg.sv
// One-cycle output stage: captures d on en, otherwise drives zero.
module nvdla_cmac_sched_oreg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= en ? d : '0;
  end
endmodule

// File: rtl/nvdla_cmac_core_wt_sched.sv
// CMAC weight/data scheduler: fills shadow kernel slots, gates stripe-start
// data beats until the shadow set is full, and counts stripes per operation.
module nvdla_cmac_core_wt_sched
  import nvdla_cmac_sched_pkg::*;
#(
  parameter int unsigned ATOMK_HALF = ATOMK_HALF_DEF,
  parameter int unsigned ATOMC      = ATOMC_DEF,
  parameter int unsigned STRIPE_W   = STRIPE_W_DEF,
  parameter int unsigned KNUM_W     = KNUM_W_DEF
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic                       op_start,
  input  logic [KNUM_W-1:0]          cfg_kernel_num,
  input  logic [STRIPE_W-1:0]        op_stripe_num,
  nvdla_cmac_core_wt_sched_if.slave  io,
  output logic                       op_busy,
  output logic                       op_done,
  output logic                       err_proto
);

  localparam logic [KNUM_W-1:0] KNUM_MAX = KNUM_W'(ATOMK_HALF);
  localparam int unsigned WT_W  = 1 + ATOMC + ATOMK_HALF;
  localparam int unsigned DAT_W = 3 + ATOMC;

  shadow_state_e         state, state_nxt;
  logic [KNUM_W-1:0]     wt_k, kernel_num, knum_m1;
  logic [STRIPE_W-1:0]   st_cnt, st_cnt_inc, cnt_eff, stripe_num;
  logic                  stripe_active;

  logic                  wt_prdy, dat_prdy;
  logic                  wt_acc, dat_acc, st_acc, end_acc;
  logic                  knum_ok, start_ok, op_go, wt_last, final_end;
  logic                  done_nxt, err_set;
  logic [ATOMK_HALF-1:0] wt_sel;

  always_comb begin
    state_nxt  = state;
    wt_prdy    = (state == S_FILL);
    dat_prdy   = op_busy && !(io.dat_in_stripe_st && (state != S_FULL));
    wt_acc     = wt_prdy && io.wt_in_pvld;
    dat_acc    = dat_prdy && io.dat_in_pvld;
    st_acc     = dat_acc && io.dat_in_stripe_st;
    end_acc    = dat_acc && io.dat_in_stripe_end;
    knum_ok    = (cfg_kernel_num != '0) && (cfg_kernel_num <= KNUM_MAX);
    start_ok   = op_start && !op_busy;
    op_go      = start_ok && knum_ok && (op_stripe_num != '0);
    knum_m1    = kernel_num - 1'b1;
    wt_last    = wt_acc && (wt_k == knum_m1);
    st_cnt_inc = st_cnt + 1'b1;
    // A one-beat stripe sees its own start before its end is judged.
    cnt_eff    = st_acc ? st_cnt_inc : st_cnt;
    final_end  = end_acc && (cnt_eff == stripe_num);
    done_nxt   = (start_ok && knum_ok && (op_stripe_num == '0)) || final_end;
    err_set    = (st_acc && stripe_active)
              || (end_acc && !stripe_active && !st_acc)
              || (start_ok && !knum_ok);
    wt_sel     = ATOMK_HALF'(onehot(32'(wt_k)));

    unique case (state)
      S_IDLE:  if (op_go) state_nxt = S_FILL;
      S_FILL:  if (wt_last) state_nxt = S_FULL;
      S_FULL:  if (st_acc) state_nxt = (st_cnt_inc < stripe_num) ? S_FILL : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign io.wt_in_prdy  = wt_prdy;
  assign io.dat_in_prdy = dat_prdy;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state         <= S_IDLE;
      wt_k          <= '0;
      st_cnt        <= '0;
      kernel_num    <= '0;
      stripe_num    <= '0;
      stripe_active <= 1'b0;
      op_busy       <= 1'b0;
      op_done       <= 1'b0;
      err_proto     <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_done <= done_nxt;
      if (err_set) err_proto <= 1'b1;
      if (op_go) begin
        op_busy       <= 1'b1;
        wt_k          <= '0;
        st_cnt        <= '0;
        kernel_num    <= cfg_kernel_num;
        stripe_num    <= op_stripe_num;
        stripe_active <= 1'b0;
      end else begin
        if (wt_acc) wt_k <= wt_last ? '0 : wt_k + 1'b1;
        if (st_acc) st_cnt <= st_cnt_inc;
        if (end_acc)     stripe_active <= 1'b0;
        else if (st_acc) stripe_active <= 1'b1;
        if (final_end) op_busy <= 1'b0;
      end
    end
  end

  logic [WT_W-1:0]  wt_q;
  logic [DAT_W-1:0] dat_q;

  nvdla_cmac_sched_oreg #(.W(WT_W)) u_wt_oreg (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .en  (wt_acc),
    .d   ({1'b1, io.wt_in_mask, wt_sel}),
    .q   (wt_q)
  );

  nvdla_cmac_sched_oreg #(.W(DAT_W)) u_dat_oreg (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .en  (dat_acc),
    .d   ({1'b1, io.dat_in_mask, io.dat_in_stripe_st, io.dat_in_stripe_end}),
    .q   (dat_q)
  );

  assign {io.in_wt_pvld, io.in_wt_mask, io.in_wt_sel} = wt_q;
  assign {io.in_dat_pvld, io.in_dat_mask, io.in_dat_stripe_st, io.in_dat_stripe_end} = dat_q;

endmodule

// File: tb/tb_nvdla_cmac_core_wt_sched.sv
// Bench for nvdla_cmac_core_wt_sched: directed scenarios plus random traffic,
// checked against a count-based model of shadow occupancy and stripe progress.
module tb_nvdla_cmac_core_wt_sched;
  import nvdla_cmac_sched_pkg::*;

  localparam int unsigned AK = 8;
  localparam int unsigned AC = 64;
  localparam int unsigned SW = 16;
  localparam int unsigned KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_start;
  logic [KW-1:0] cfg_kernel_num;
  logic [SW-1:0] op_stripe_num;
  logic          op_busy, op_done, err_proto;

  nvdla_cmac_core_wt_sched_if #(.ATOMK_HALF(AK), .ATOMC(AC)) io ();

  nvdla_cmac_core_wt_sched #(
    .ATOMK_HALF (AK),
    .ATOMC      (AC),
    .STRIPE_W   (SW),
    .KNUM_W     (KW)
  ) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .op_start       (op_start),
    .cfg_kernel_num (cfg_kernel_num),
    .op_stripe_num  (op_stripe_num),
    .io             (io),
    .op_busy        (op_busy),
    .op_done        (op_done),
    .err_proto      (err_proto)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: shadow occupancy and stripe progress as plain counts.
  bit          m_busy, m_active, m_err;
  int          m_k, m_n, m_loaded, m_started;
  bit          e_wt_pvld, e_dat_pvld, e_st, e_end, e_done;
  logic [63:0] e_wt_mask, e_dat_mask;
  logic [7:0]  e_wt_sel;

  task automatic model_clear();
    m_busy = 0; m_active = 0; m_err = 0;
    m_k = 0; m_n = 0; m_loaded = 0; m_started = 0;
    e_wt_pvld = 0; e_dat_pvld = 0; e_st = 0; e_end = 0; e_done = 0;
    e_wt_mask = '0; e_dat_mask = '0; e_wt_sel = '0;
  endtask

  // Inputs are set before the call; returns 1 ns after the next rising edge.
  task automatic run_cycle();
    bit full, wr, dr, wa, da;
    #2;
    full = m_busy && (m_started < m_n) && (m_loaded == m_k);
    wr   = m_busy && (m_started < m_n) && (m_loaded < m_k);
    dr   = m_busy && !(io.dat_in_stripe_st && !full);
    check("wt_in_prdy",  64'(io.wt_in_prdy),  64'(wr));
    check("dat_in_prdy", 64'(io.dat_in_prdy), 64'(dr));
    wa = wr && io.wt_in_pvld;
    da = dr && io.dat_in_pvld;
    if (rst) begin
      model_clear();
    end else begin
      e_done = 0;
      if (op_start && !m_busy) begin
        if (cfg_kernel_num == 0 || int'(cfg_kernel_num) > 8) m_err = 1;
        else if (op_stripe_num == 0) e_done = 1;
        else begin
          m_busy = 1; m_k = int'(cfg_kernel_num); m_n = int'(op_stripe_num);
          m_loaded = 0; m_started = 0; m_active = 0;
        end
      end
      e_wt_pvld  = wa;
      e_wt_mask  = wa ? io.wt_in_mask : '0;
      e_wt_sel   = wa ? 8'(1 << m_loaded) : '0;
      if (wa) m_loaded++;
      e_dat_pvld = da;
      e_dat_mask = da ? io.dat_in_mask : '0;
      e_st       = da && io.dat_in_stripe_st;
      e_end      = da && io.dat_in_stripe_end;
      if (e_st) begin
        if (m_active) m_err = 1;
        m_started++; m_loaded = 0; m_active = 1;
      end
      if (e_end) begin
        if (!m_active) m_err = 1;
        m_active = 0;
        if (m_started == m_n) begin m_busy = 0; e_done = 1; end
      end
    end
    @(posedge clk); #1;
    check("in_wt_pvld",   64'(io.in_wt_pvld),        64'(e_wt_pvld));
    check("in_wt_mask",   io.in_wt_mask,             e_wt_mask);
    check("in_wt_sel",    64'(io.in_wt_sel),         64'(e_wt_sel));
    check("in_dat_pvld",  64'(io.in_dat_pvld),       64'(e_dat_pvld));
    check("in_dat_mask",  io.in_dat_mask,            e_dat_mask);
    check("in_dat_st",    64'(io.in_dat_stripe_st),  64'(e_st));
    check("in_dat_end",   64'(io.in_dat_stripe_end), 64'(e_end));
    check("op_busy",      64'(op_busy),              64'(m_busy));
    check("op_done",      64'(op_done),              64'(e_done));
    check("err_proto",    64'(err_proto),            64'(m_err));
  endtask

  task automatic drive_streams(input bit wv, input bit dv, input bit st, input bit en);
    io.wt_in_pvld        = wv;
    io.wt_in_mask        = {$urandom, $urandom};
    io.dat_in_pvld       = dv;
    io.dat_in_mask       = {$urandom, $urandom};
    io.dat_in_stripe_st  = st;
    io.dat_in_stripe_end = en;
  endtask

  task automatic start_op(input int k, input int n);
    op_start = 1; cfg_kernel_num = KW'(k); op_stripe_num = SW'(n);
    run_cycle();
    op_start = 0;
  endtask

  task automatic run_n(input int n, input bit wv, input bit dv, input bit st, input bit en);
    for (int i = 0; i < n; i++) begin
      drive_streams(wv, dv, st, en);
      run_cycle();
    end
  endtask

  task automatic rand_inputs();
    bit st, en;
    rst      = ($urandom_range(0, 299) == 0);
    op_start = m_busy ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 4) == 0);
    cfg_kernel_num = ($urandom_range(0, 15) == 0) ? KW'($urandom_range(9, 15) & 4'hF)
                                                  : KW'($urandom_range(1, 8));
    if ($urandom_range(0, 30) == 0) cfg_kernel_num = '0;
    op_stripe_num = SW'($urandom_range(0, 4));
    if (m_active) begin
      st = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 2) == 0);
    end else begin
      st = ($urandom_range(0, 2) != 0);
      en = st ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
    end
    drive_streams($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, st, en);
  endtask

  initial begin
    rst = 1; op_start = 0; cfg_kernel_num = '0; op_stripe_num = '0;
    drive_streams(0, 0, 0, 0);
    model_clear();
    @(posedge clk); #1;
    run_n(2, 0, 0, 0, 0);
    rst = 0;

    // Full group of 8, one-beat stripe waiting from the start.
    start_op(8, 1);
    run_n(12, 1, 1, 1, 1);
    // k=3, three back-to-back one-beat stripes.
    start_op(3, 3);
    run_n(20, 1, 1, 1, 1);
    // Zero-stripe op, then illegal kernel count.
    start_op(4, 0);
    run_n(3, 1, 1, 1, 1);
    start_op(9, 2);
    run_n(3, 1, 1, 1, 1);
    rst = 1; run_n(1, 0, 0, 0, 0); rst = 0;
    // Two stripe starts with no end between them.
    start_op(1, 2);
    run_n(10, 1, 1, 1, 0);
    rst = 1; run_n(1, 0, 0, 0, 0); rst = 0;
    // Reset mid-fill, then a fresh op.
    start_op(8, 1);
    run_n(4, 1, 0, 0, 0);
    rst = 1; run_n(1, 1, 0, 0, 0); rst = 0;
    run_n(2, 0, 0, 0, 0);
    start_op(2, 1);
    run_n(6, 1, 1, 1, 1);

    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
